// File: rtl/exc_ctrl.sv
// ============================================================================
// exc_ctrl: sequences CP0 EPC/Cause/Status writes and the PC redirect for
// exceptions, interrupts and ERET.   Rev 1.0
// ============================================================================
`default_nettype none

module exc_ctrl #(
  parameter logic [31:0] P_EXC_VECTOR = 32'h0000_0020,
  parameter int          P_CP0_AW     = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_exc_valid,
  input  logic [4:0]          i_exc_code,
  input  logic                i_eret,
  input  logic                i_pc_valid,
  input  logic [31:0]         i_pc,
  input  logic                i_in_dslot,
  input  logic [31:0]         i_status,
  input  logic [31:0]         i_cause,
  input  logic [31:0]         i_epc,
  output logic                o_cp0_w_en,
  output logic [P_CP0_AW-1:0] o_cp0_w_addr,
  output logic [31:0]         o_cp0_w_data,
  output logic                o_stall,
  output logic                o_flush,
  output logic [31:0]         o_new_pc,
  output logic                o_busy
);

  localparam logic [P_CP0_AW-1:0] C_ADDR_STATUS = P_CP0_AW'(12);
  localparam logic [P_CP0_AW-1:0] C_ADDR_CAUSE  = P_CP0_AW'(13);
  localparam logic [P_CP0_AW-1:0] C_ADDR_EPC    = P_CP0_AW'(14);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EPC    = 3'd1,
    S_W_CAUSE  = 3'd2,
    S_W_STATUS = 3'd3,
    S_REDIRECT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        dslot_q, dslot_d;
  logic [4:0]  code_q, code_d;
  logic        eret_q, eret_d;
  logic        exl_old_q, exl_old_d;

  logic        w_irq;
  logic        w_take_eret;
  logic        w_bd;
  logic        w_stall;

  assign w_irq       = (|(i_cause[15:8] & i_status[15:8])) & i_status[0] & ~i_status[1];
  assign w_take_eret = ~i_exc_valid & i_eret;
  // A nested exception leaves EPC alone, so BD must keep its current value too.
  assign w_bd        = exl_old_q ? i_cause[31] : dslot_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      dslot_q   <= 1'b0;
      code_q    <= 5'd0;
      eret_q    <= 1'b0;
      exl_old_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dslot_q   <= dslot_d;
      code_q    <= code_d;
      eret_q    <= eret_d;
      exl_old_q <= exl_old_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dslot_d      = dslot_q;
    code_d       = code_q;
    eret_d       = eret_q;
    exl_old_d    = exl_old_q;
    o_cp0_w_en   = 1'b0;
    o_cp0_w_addr = '0;
    o_cp0_w_data = 32'd0;
    w_stall      = 1'b0;
    o_flush      = 1'b0;
    o_new_pc     = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (i_exc_valid || i_eret || (w_irq && i_pc_valid)) begin
          w_stall   = 1'b1;
          pc_d      = i_pc;
          dslot_d   = i_in_dslot;
          code_d    = i_exc_valid ? i_exc_code : 5'd0;
          eret_d    = w_take_eret;
          exl_old_d = i_status[1];
          if (w_take_eret)      state_d = S_W_STATUS;
          else if (i_status[1]) state_d = S_W_CAUSE;
          else                  state_d = S_W_EPC;
        end
      end
      S_W_EPC: begin
        o_cp0_w_en   = 1'b1;
        o_cp0_w_addr = C_ADDR_EPC;
        o_cp0_w_data = dslot_q ? (pc_q - 32'd4) : pc_q;
        w_stall      = 1'b1;
        state_d      = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        o_cp0_w_en   = 1'b1;
        o_cp0_w_addr = C_ADDR_CAUSE;
        o_cp0_w_data = {w_bd, i_cause[30:7], code_q, i_cause[1:0]};
        w_stall      = 1'b1;
        state_d      = S_W_STATUS;
      end
      S_W_STATUS: begin
        o_cp0_w_en   = 1'b1;
        o_cp0_w_addr = C_ADDR_STATUS;
        o_cp0_w_data = {i_status[31:2], ~eret_q, i_status[0]};
        w_stall      = 1'b1;
        state_d      = S_REDIRECT;
      end
      S_REDIRECT: begin
        o_flush  = 1'b1;
        o_new_pc = eret_q ? i_epc : P_EXC_VECTOR;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The acceptance stall is combinational on inputs, so mask it during reset.
  assign o_stall = w_stall & i_rst_n;
  assign o_busy  = (state_q != S_IDLE);

endmodule

`default_nettype wire
